riscv_apb_lsu_bridge: RTL

Parametrised load/store front-end between the RISC-V core and the APB master. It decodes lw/lh/lb/lbu/lhu/sw/sh/sb from the current instruction and computes the effective address. Accesses that fall inside a configurable APB window are diverted to the APB master, with byte strobes, lane-aligned write data, sign/zero-extended read return, a transfer timeout and error reporting. The PC is stalled and the data memory is cancelled for the whole transaction.

---
 rtl/riscv_apb_lsu_bridge_pkg.sv | 34 +++
 rtl/riscv_apb_lsu_bridge_if.sv | 28 ++
 rtl/riscv_apb_lsu_bridge_lane_align.sv | 68 ++++++
 rtl/riscv_apb_lsu_bridge.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_apb_lsu_bridge_pkg.sv
// Shared definitions for the RISC-V load/store to APB bridge.
// Contents: RV32 load/store opcodes, access-size encodings (these match
// funct3[1:0]), bridge FSM states, error cause codes, and a misalignment
// helper used during decode.
package riscv_apb_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN,
        ERR
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_SLVERR   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // A halfword must sit on an even address.
    // A word must sit on a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        return ((size == SIZE_H) && lane[0]) || ((size == SIZE_W) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/riscv_apb_lsu_bridge_if.sv
// Bus bundle between the load/store bridge and the APB master.
//   master modport (bridge side):
//     drives transfer/SWRITE/SADDR/SWDATA/SSTRB
//     receives READY/SLVERR/PRDATA
//   slave modport (APB master side): the mirror image.
interface riscv_apb_lsu_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              transfer;
    logic              SWRITE;
    logic [ADDR_W-1:0] SADDR;
    logic [DATA_W-1:0] SWDATA;
    logic [3:0]        SSTRB;
    logic              READY;
    logic              SLVERR;
    logic [DATA_W-1:0] PRDATA;

    modport master (
        output transfer, SWRITE, SADDR, SWDATA, SSTRB,
        input  READY, SLVERR, PRDATA
    );

    modport slave (
        input  transfer, SWRITE, SADDR, SWDATA, SSTRB,
        output READY, SLVERR, PRDATA
    );
endinterface

// File: rtl/riscv_apb_lsu_bridge_lane_align.sv
// apb_lane_align: combinational byte-lane steering for a 32-bit data bus.
// Inputs:
//   size    - access size (SIZE_B/H/W)
//   sign    - 1 sign-extends a load, 0 zero-extends it
//   lane    - ea[1:0]
//   wr_data - store data
//   rd_data - raw bus read data
// Outputs:
//   strb    - byte strobes
//   wdata   - lane-replicated store data
//   ldata   - extracted and extended load value
// Has no bus-specific logic, so an AHB path can reuse it.
module apb_lane_align
    import riscv_apb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [1:0]        lane,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic [3:0]        strb,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ldata
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Pick the addressed byte and halfword out of the read word.
    // Then shape strobes, write data and the extended load value by size.
    always_comb begin
        strb    = 4'b0000;
        wdata   = '0;
        ldata   = '0;
        rd_half = lane[1] ? rd_data[31:16] : rd_data[15:0];
        case (lane)
            2'd0:    rd_byte = rd_data[7:0];
            2'd1:    rd_byte = rd_data[15:8];
            2'd2:    rd_byte = rd_data[23:16];
            default: rd_byte = rd_data[31:24];
        endcase
        case (size)
            SIZE_B: begin
                strb  = 4'b0001 << lane;
                wdata = {4{wr_data[7:0]}};
                ldata = {{24{sign & rd_byte[7]}}, rd_byte};
            end
            SIZE_H: begin
                strb  = 4'b0011 << lane;
                wdata = {2{wr_data[15:0]}};
                ldata = {{16{sign & rd_half[15]}}, rd_half};
            end
            SIZE_W: begin
                strb  = 4'b1111;
                wdata = wr_data;
                ldata = rd_data;
            end
            default: begin
                strb  = 4'b0000;
                wdata = '0;
                ldata = '0;
            end
        endcase
    end

endmodule

// File: rtl/riscv_apb_lsu_bridge.sv
// riscv_apb_lsu_bridge: load/store front-end that diverts accesses inside the
// APB window to the APB master. It stalls the PC and cancels the data memory
// while the access is in flight.
// Ports:
//   clk, rst (synchronous, active-low)
//   instruction, RD1 (base), RD2 (store data)  - from the core
//   bus (master modport)                       - APB master handshake
//   stop, cancel_data_memory                   - pipeline control
//   load_data, load_valid                      - load writeback pulse
//   err_valid, err_cause, err_addr             - error reporting
// Only the 32-bit data bus (DATA_W = 32) is supported.
module riscv_apb_lsu_bridge
    import riscv_apb_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] APB_BASE  = 32'd1000,
    parameter logic [ADDR_W-1:0] APB_LIMIT = 32'hEFFF_FFFF,
    parameter int unsigned       TIMEOUT   = 64,
    parameter int unsigned       TO_W      = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instruction,
    input  logic [ADDR_W-1:0]     RD1,
    input  logic [DATA_W-1:0]     RD2,
    riscv_apb_lsu_bridge_if.master bus,
    output logic                  stop,
    output logic                  cancel_data_memory,
    output logic [DATA_W-1:0]     load_data,
    output logic                  load_valid,
    output logic                  err_valid,
    output logic [1:0]            err_cause,
    output logic [ADDR_W-1:0]     err_addr
);

    state_e            cs, ns;
    logic [TO_W-1:0]   cnt;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              is_load, is_store, valid_op, in_window, hit, misaligned, timeout;
    logic [ADDR_W-1:0] imm, ea;
    logic [ADDR_W-1:0] saddr_q;
    logic              swrite_q, sign_q;
    logic [1:0]        size_q, aln_size, aln_lane;
    logic [3:0]        sstrb_q, aln_strb;
    logic [DATA_W-1:0] swdata_q, aln_wdata, aln_ldata;
    logic              unused_rs1;

    assign opcode   = instruction[6:0];
    assign funct3   = instruction[14:12];
    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);

    // The rs1 field is already resolved into RD1 by the register file.
    assign unused_rs1 = ^instruction[19:15];

    // Size 11 has no meaning.
    // Stores have no zero-extending form.
    assign valid_op = (funct3[1:0] != 2'b11) && (is_load || (is_store && !funct3[2]));

    assign imm = is_store ? {{(ADDR_W-12){instruction[31]}}, instruction[31:25], instruction[11:7]}
                          : {{(ADDR_W-12){instruction[31]}}, instruction[31:20]};
    assign ea         = RD1 + imm;
    assign in_window  = (ea >= APB_BASE) && (ea <= APB_LIMIT);
    assign hit        = valid_op && in_window;
    assign misaligned = is_misaligned(funct3[1:0], ea[1:0]);
    assign timeout    = (cnt == TO_W'(TIMEOUT - 1));

    // One aligner serves both directions.
    // In IDLE it shapes the store being captured from the current decode.
    // In REQ it extracts the load from the transaction's latched size and lane.
    assign aln_size = (cs == IDLE) ? funct3[1:0] : size_q;
    assign aln_lane = (cs == IDLE) ? ea[1:0] : saddr_q[1:0];

    apb_lane_align #(.DATA_W(DATA_W)) u_align (
        .size    (aln_size),
        .sign    (sign_q),
        .lane    (aln_lane),
        .wr_data (RD2),
        .rd_data (bus.PRDATA),
        .strb    (aln_strb),
        .wdata   (aln_wdata),
        .ldata   (aln_ldata)
    );

    // Next-state logic.
    // Reset forces IDLE here as well, so stop drops while rst is held low.
    always_comb begin
        ns = cs;
        if (!rst) begin
            ns = IDLE;
        end else begin
            case (cs)
                IDLE:    if (hit) ns = misaligned ? ERR : REQ;
                REQ:     if (bus.READY) ns = DRAIN;
                         else if (timeout) ns = ERR;
                DRAIN:   if (!bus.READY) ns = IDLE;
                default: ns = IDLE;
            endcase
        end
    end

    // State, transfer attributes, the timeout counter and the one-cycle
    // result pulses.
    // Attributes are captured on the IDLE->REQ edge, so later changes to
    // RD1/RD2 cannot disturb an access in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cs         <= IDLE;
            cnt        <= '0;
            saddr_q    <= '0;
            swrite_q   <= 1'b0;
            swdata_q   <= '0;
            sstrb_q    <= 4'b0000;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            load_data  <= '0;
            load_valid <= 1'b0;
            err_valid  <= 1'b0;
            err_cause  <= ERR_NONE;
            err_addr   <= '0;
        end else begin
            cs         <= ns;
            load_valid <= 1'b0;
            err_valid  <= 1'b0;
            load_data  <= '0;
            if ((cs == REQ) && (ns == REQ)) cnt <= cnt + 1'b1;
            else                            cnt <= '0;
            case (cs)
                IDLE: begin
                    if (hit && misaligned) begin
                        err_valid <= 1'b1;
                        err_cause <= ERR_MISALIGN;
                        err_addr  <= ea;
                    end else if (hit) begin
                        saddr_q  <= ea;
                        swrite_q <= is_store;
                        size_q   <= funct3[1:0];
                        sign_q   <= !funct3[2];
                        swdata_q <= is_store ? aln_wdata : '0;
                        sstrb_q  <= is_store ? aln_strb : 4'b0000;
                    end
                end
                REQ: begin
                    if (bus.READY) begin
                        if (bus.SLVERR) begin
                            err_valid <= 1'b1;
                            err_cause <= ERR_SLVERR;
                            err_addr  <= saddr_q;
                        end else if (!swrite_q) begin
                            load_valid <= 1'b1;
                            load_data  <= aln_ldata;
                        end
                    end else if (timeout) begin
                        err_valid <= 1'b1;
                        err_cause <= ERR_TIMEOUT;
                        err_addr  <= saddr_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stop               = (ns != IDLE);
    assign cancel_data_memory = stop | (cs != IDLE);

    assign bus.transfer = (cs == REQ);
    assign bus.SWRITE   = swrite_q;
    assign bus.SADDR    = saddr_q;
    assign bus.SWDATA   = swdata_q;
    assign bus.SSTRB    = sstrb_q;

endmodule
